// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache in front of a 1-cycle synchronous SRAM.
// Define DCACHE_STATS_EN to build the hitnum/missnum counters; otherwise they read as zero.
module dcache_direct_mapped #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int AWIDTH         = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CACHE_CSN,
  input  logic              CACHE_WEN,
  input  logic [AWIDTH-1:0] CACHE_ADDR,
  input  logic [31:0]       CACHE_DI,
  output logic [31:0]       CACHE_DOUT,
  output logic              CACHE_MISS,
  output logic              D_MEM_CSN,
  output logic              D_MEM_WEN,
  output logic [3:0]        D_MEM_BE,
  output logic [AWIDTH-1:0] D_MEM_ADDR,
  output logic [31:0]       D_MEM_DOUT,
  input  logic [31:0]       D_MEM_DI,
  output logic [31:0]       hitnum,
  output logic [31:0]       missnum
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = AWIDTH - OFF_W - IDX_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_WB  = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] FILL_END = CNT_W'(WORDS_PER_LINE);
  localparam logic [OFF_W-1:0] LAST_OFF = '1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [NUM_LINES];
  logic [31:0]      data_q [NUM_LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] mem_off;
  logic [CNT_W-1:0] cnt_m1;
  logic [OFF_W-1:0] fill_off;
  logic             hit;
  logic             serve;
  logic             miss_start;

  assign req_off = CACHE_ADDR[OFF_W-1:0];
  assign req_idx = CACHE_ADDR[OFF_W +: IDX_W];
  assign req_tag = CACHE_ADDR[AWIDTH-1 -: TAG_W];

  assign hit        = !CACHE_CSN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign serve      = ((state == S_IDLE) && hit) || ((state == S_DONE) && !CACHE_CSN);
  assign miss_start = (state == S_IDLE) && !CACHE_CSN && !hit;

  assign CACHE_MISS = miss_start || (state == S_WB) || (state == S_FILL);
  assign CACHE_DOUT = (serve && CACHE_WEN) ? data_q[{req_idx, req_off}] : '0;

  // The extra FILL cycle only collects the last word, so the address holds on the last offset.
  assign mem_off  = (cnt > LAST_WB) ? LAST_OFF : cnt[OFF_W-1:0];
  assign cnt_m1   = cnt - CNT_W'(1);
  assign fill_off = cnt_m1[OFF_W-1:0];

  always_comb begin
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_BE   = '0;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;
    case (state)
      S_WB: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = 1'b0;
        D_MEM_BE   = '1;
        D_MEM_ADDR = {tag_q[req_idx], req_idx, mem_off};
        D_MEM_DOUT = data_q[{req_idx, mem_off}];
      end
      S_FILL: begin
        D_MEM_CSN  = 1'b0;
        D_MEM_BE   = '1;
        D_MEM_ADDR = {req_tag, req_idx, mem_off};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit && !CACHE_WEN) dirty_q[req_idx] <= 1'b1;
          if (miss_start) begin
            cnt   <= '0;
            state <= (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (cnt == LAST_WB) begin
            cnt   <= '0;
            state <= S_FILL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FILL: begin
          if (cnt == FILL_END) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            state            <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (!CACHE_CSN && !CACHE_WEN) dirty_q[req_idx] <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Line storage carries no reset; a line is only trusted through its valid bit.
  always_ff @(posedge CLK) begin
    if (serve && !CACHE_WEN) data_q[{req_idx, req_off}] <= CACHE_DI;
    if ((state == S_FILL) && (cnt != '0)) data_q[{req_idx, fill_off}] <= D_MEM_DI;
    if ((state == S_FILL) && (cnt == FILL_END)) tag_q[req_idx] <= req_tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && hit) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hitnum  = hit_cnt;
  assign missnum = miss_cnt;
`else
  assign hitnum  = '0;
  assign missnum = '0;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped against a 4096x32 synchronous SRAM model.
// Counter expectations follow DCACHE_STATS_EN (zero when the counters are not built).
module tb_dcache_direct_mapped;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK;
  logic        RSTn;
  logic        CACHE_CSN;
  logic        CACHE_WEN;
  logic [11:0] CACHE_ADDR;
  logic [31:0] CACHE_DI;
  logic [31:0] CACHE_DOUT;
  logic        CACHE_MISS;
  logic        D_MEM_CSN;
  logic        D_MEM_WEN;
  logic [3:0]  D_MEM_BE;
  logic [11:0] D_MEM_ADDR;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI;
  logic [31:0] hitnum;
  logic [31:0] missnum;

  dcache_direct_mapped #(.NUM_LINES(8), .WORDS_PER_LINE(4), .AWIDTH(12)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CACHE_CSN(CACHE_CSN), .CACHE_WEN(CACHE_WEN), .CACHE_ADDR(CACHE_ADDR),
    .CACHE_DI(CACHE_DI), .CACHE_DOUT(CACHE_DOUT), .CACHE_MISS(CACHE_MISS),
    .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI),
    .hitnum(hitnum), .missnum(missnum)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SRAM model: unwritten words read as A5A5_0000 | address.
  logic [31:0] mem     [4096];
  logic        written [4096];
  logic        mem_clr;
  logic [11:0] rd_q[$];
  logic [11:0] wr_q[$];
  int          act_cnt;

  function automatic logic [31:0] mem_rd(input logic [11:0] a);
    return written[a] ? mem[a] : (32'hA5A5_0000 | {20'd0, a});
  endfunction

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
      act_cnt <= 0;
    end else if (!D_MEM_CSN) begin
      act_cnt <= act_cnt + 1;
      if (!D_MEM_WEN) begin
        mem[D_MEM_ADDR]     <= D_MEM_DOUT;
        written[D_MEM_ADDR] <= 1'b1;
        wr_q.push_back(D_MEM_ADDR);
      end else begin
        D_MEM_DI <= mem_rd(D_MEM_ADDR);
        rd_q.push_back(D_MEM_ADDR);
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input logic [31:0] v);
    return STATS ? v : 32'd0;
  endfunction

  // Issue one request at #1 after an edge; returns stall cycles seen after the request edge.
  task automatic access(input logic wen, input logic [11:0] a, input logic [31:0] d,
                        output int stall, output logic [31:0] dout);
    CACHE_CSN = 1'b0; CACHE_WEN = wen; CACHE_ADDR = a; CACHE_DI = d;
    stall = 0;
    @(negedge CLK);
    if (!CACHE_MISS) begin
      dout = CACHE_DOUT;
      @(posedge CLK); #1;
    end else begin
      @(posedge CLK); #1;
      while (CACHE_MISS && stall < 40) begin
        stall++;
        @(posedge CLK); #1;
      end
      dout = CACHE_DOUT;
      @(posedge CLK); #1;
    end
    CACHE_CSN = 1'b1; CACHE_WEN = 1'b1;
  endtask

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [31:0] di;
    int          stall;
    logic [31:0] dout;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t        vt[13];
  int          st;
  logic [31:0] dv;
  int          a0;

  initial begin
    vt[0]  = '{1'b1, 12'h010, 32'h0,         5, 32'hA5A5_0010, 0, 1};
    vt[1]  = '{1'b1, 12'h011, 32'h0,         0, 32'hA5A5_0011, 1, 1};
    vt[2]  = '{1'b0, 12'h010, 32'h1234_5678, 0, 32'h0,         2, 1};
    vt[3]  = '{1'b1, 12'h013, 32'h0,         0, 32'hA5A5_0013, 3, 1};
    vt[4]  = '{1'b1, 12'h110, 32'h0,         9, 32'hA5A5_0110, 3, 2};
    vt[5]  = '{1'b1, 12'h010, 32'h0,         5, 32'h1234_5678, 3, 3};
    vt[6]  = '{1'b0, 12'h01F, 32'hDEAD_BEEF, 5, 32'h0,         3, 4};
    vt[7]  = '{1'b1, 12'h01F, 32'h0,         0, 32'hDEAD_BEEF, 4, 4};
    vt[8]  = '{1'b1, 12'h0FF, 32'h0,         9, 32'hA5A5_00FF, 4, 5};
    vt[9]  = '{1'b1, 12'h01F, 32'h0,         5, 32'hDEAD_BEEF, 4, 6};
    vt[10] = '{1'b1, 12'h000, 32'h0,         5, 32'hA5A5_0000, 4, 7};
    vt[11] = '{1'b1, 12'hFFF, 32'h0,         5, 32'hA5A5_0FFF, 4, 8};
    vt[12] = '{1'b1, 12'hFFC, 32'h0,         0, 32'hA5A5_0FFC, 5, 8};

    RSTn = 1'b0; mem_clr = 1'b1;
    CACHE_CSN = 1'b1; CACHE_WEN = 1'b1; CACHE_ADDR = '0; CACHE_DI = '0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1; mem_clr = 1'b0;

    check("rst_hitnum", hitnum, 32'd0);
    check("rst_missnum", missnum, 32'd0);
    check("rst_miss", {31'd0, CACHE_MISS}, 32'd0);
    check("rst_mem_csn", {31'd0, D_MEM_CSN}, 32'd1);
    check("rst_dout", CACHE_DOUT, 32'd0);

    for (int i = 0; i < 13; i++) begin
      rd_q.delete();
      wr_q.delete();
      access(vt[i].wen, vt[i].addr, vt[i].di, st, dv);
      check($sformatf("v%0d_stall", i), st, vt[i].stall);
      check($sformatf("v%0d_dout", i), dv, vt[i].dout);
      check($sformatf("v%0d_hitnum", i), hitnum, ecnt(vt[i].hits));
      check($sformatf("v%0d_missnum", i), missnum, ecnt(vt[i].misses));
      if (i == 0) begin
        check("fill_rd_count_min", {31'd0, rd_q.size() >= 4}, 32'd1);
        for (int k = 0; k < 4; k++)
          check($sformatf("fill_rd%0d", k), (k < rd_q.size()) ? {20'd0, rd_q[k]} : 32'hFFFF_FFFF,
                32'h010 + k);
      end
      if (i == 4 || i == 8) begin
        check($sformatf("v%0d_wb_count", i), wr_q.size(), 4);
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d_wb_addr%0d", i, k),
                (k < wr_q.size()) ? {20'd0, wr_q[k]} : 32'hFFFF_FFFF,
                ((i == 4) ? 32'h010 : 32'h01C) + k);
      end
      if (i == 4) begin
        check("wb_mem_010", mem_rd(12'h010), 32'h1234_5678);
        check("wb_mem_011", mem_rd(12'h011), 32'hA5A5_0011);
      end
      if (i == 8) check("wb_mem_01F", mem_rd(12'h01F), 32'hDEAD_BEEF);
    end

    // Deselected: no memory traffic, no stall, counters frozen.
    a0 = act_cnt;
    repeat (10) @(posedge CLK);
    #1;
    check("idle_mem_activity", act_cnt - a0, 32'd0);
    check("idle_miss", {31'd0, CACHE_MISS}, 32'd0);
    check("idle_hitnum", hitnum, ecnt(5));
    check("idle_missnum", missnum, ecnt(8));

    // Reset in the middle of a refill of line 0.
    CACHE_CSN = 1'b0; CACHE_WEN = 1'b1; CACHE_ADDR = 12'h200;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_rst_miss", {31'd0, CACHE_MISS}, 32'd1);
    check("pre_rst_mem_csn", {31'd0, D_MEM_CSN}, 32'd0);
    RSTn = 1'b0;
    @(posedge CLK); #1;
    check("midfill_rst_mem_csn", {31'd0, D_MEM_CSN}, 32'd1);
    check("midfill_rst_mem_be", {28'd0, D_MEM_BE}, 32'd0);
    check("midfill_rst_hitnum", hitnum, 32'd0);
    check("midfill_rst_missnum", missnum, 32'd0);
    RSTn = 1'b1; CACHE_CSN = 1'b1;
    @(posedge CLK); #1;

    access(1'b1, 12'h200, 32'h0, st, dv);
    check("rerd_200_stall", st, 5);
    check("rerd_200_dout", dv, 32'hA5A5_0200);
    check("rerd_200_missnum", missnum, ecnt(1));
    access(1'b1, 12'hFFC, 32'h0, st, dv);
    check("rerd_FFC_stall", st, 5);
    check("rerd_FFC_dout", dv, 32'hA5A5_0FFC);
    check("rerd_hitnum", hitnum, ecnt(0));
    check("rerd_missnum", missnum, ecnt(2));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Direct-mapped, write-back, write-allocate data cache between the RISC-V core's load/store port and a single-port word-addressed data SRAM (4096 x 32, 1-cycle synchronous read).
- Hits are served combinationally.
- Misses assert a stall (CACHE_MISS) while the block writes back and refills a line.
- Keeps 32-bit hit and miss counters for end-of-run reporting.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2).
- AWIDTH, 12, word-address width on both CPU and memory sides.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- CACHE_CSN  in  1  CPU request select, active-low.
- CACHE_WEN  in  1  CPU write enable, active-low (1 = read).
- CACHE_ADDR  in  12  CPU word address.
- CACHE_DI  in  32  CPU write data.
- CACHE_DOUT  out  32  CPU read data.
- CACHE_MISS  out  1  stall to CPU; request must be held stable while high.
- D_MEM_CSN  out  1  memory select, active-low.
- D_MEM_WEN  out  1  memory write enable, active-low.
- D_MEM_BE  out  4  memory byte enables.
- D_MEM_ADDR  out  12  memory word address.
- D_MEM_DOUT  out  32  memory write data.
- D_MEM_DI  in  32  memory read data, valid the cycle after the address.
- hitnum  out  32  hit count.
- missnum  out  32  miss count.

Behaviour:
- Address split (defaults):
  - offset = ADDR[1:0]
  - index = ADDR[4:2]
  - tag = ADDR[11:5]
- Per line: valid, dirty, tag, WORDS_PER_LINE data words.
- Hit = CSN low & valid[index] & tag match. Evaluated combinationally in IDLE.
- Read hit: CACHE_DOUT = line word, same cycle; CACHE_MISS = 0.
- Write hit: word updated at the next edge; dirty set; CACHE_MISS = 0.
- CACHE_DOUT = 0 when not a read hit.
- Miss (CSN low, no hit, in IDLE):
  - CACHE_MISS = 1 combinationally.
  - FSM moves to WB if the victim is valid and dirty, else to FILL.
- FSM states:
  - IDLE: serves hits.
  - WB: one memory write per cycle, for WORDS_PER_LINE cycles.
    - D_MEM_CSN = 0, D_MEM_WEN = 0, D_MEM_BE = 4'b1111.
    - D_MEM_ADDR = {victim tag, index, k}, D_MEM_DOUT = victim word k.
    - Then go to FILL.
  - FILL: read words k = 0..3 at {req tag, index, k}, one per cycle.
    - D_MEM_CSN = 0, D_MEM_WEN = 1, D_MEM_BE = 4'b1111.
    - Each word is captured from D_MEM_DI one cycle after its address; the last capture takes one extra cycle (5 cycles total).
    - On completion: tag written, valid = 1, dirty = 0; go to DONE.
  - DONE: one cycle, CACHE_MISS = 0.
    - Request is served as a hit. A write merges and sets dirty.
    - Not counted as a hit. Return to IDLE.
- CACHE_MISS is 1 throughout WB and FILL.
- Default latencies:
  - Clean miss: 5 stall cycles.
  - Dirty miss: 9 stall cycles.
- Outside WB/FILL: D_MEM_CSN = 1, D_MEM_WEN = 1, D_MEM_BE = 0, D_MEM_ADDR = 0, D_MEM_DOUT = 0.
- Counters:
  - missnum += 1 on each IDLE->WB/FILL transition.
  - hitnum += 1 each cycle in IDLE with a hit.
  - Both wrap at 2^32.
- CSN high in IDLE: no state change, CACHE_MISS = 0.
- Reset (RSTn low at an edge), from any state including mid-WB/FILL:
  - All valid and dirty bits cleared; FSM to IDLE; counters to 0.
  - Outputs return to their idle values above. A partially filled line stays invalid.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: hitnum/missnum count as specified.
- Undefined: counter registers are not built; hitnum and missnum are tied to 0; all other behaviour is unchanged.

Test Plan:
- Reset, then read addr 0x010 (memory word 0x010 = 0xA5A5_0010) -> CACHE_MISS high 5 cycles; memory reads 0x010..0x013; DOUT = 0xA5A5_0010 in DONE; missnum = 1, hitnum = 0.
- Read 0x011 next -> same-cycle DOUT = mem[0x011], no stall; hitnum = 1.
- Write 0x12345678 to 0x010 (hit), then read 0x110 (same index 4, different tag) -> 4 memory writes, with 0x010 = 0x12345678, then 4 fills; CACHE_MISS high 9 cycles; missnum = 2.
- Read 0x010 again -> clean miss, 5 stall cycles, DOUT = 0x12345678.
- CSN held high for 10 cycles -> no memory activity; counters unchanged.
- Assert RSTn low during FILL -> next cycle IDLE, counters 0, D_MEM_CSN = 1; a re-read of the same address misses again.
